// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-bus package: bus command and access-size encodings, tag
// geometry, and the arbiter's tag-table entry types.
package mem_bus_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int TAG_W    = 4;
  localparam int NUM_TAGS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef enum logic {
    ARB_IC = 1'b0,
    ARB_DC = 1'b1
  } ARB_OWNER;

  typedef struct packed {
    logic     valid;
    ARB_OWNER owner;
    logic     squashed;
  } ARB_TAG_ENTRY;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load tag table for the memory bus arbiter.
// Tracks {valid, owner, squashed} per memory tag, decides where a returning
// tag goes, and reports live (non-squashed) load counts per owner.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   i_alloc_en/tag/owner: accepted load allocates i_alloc_tag for i_alloc_owner
//   i_squash            : mark every icache entry squashed
//   i_ret_tag           : tag memory is returning this cycle (0 = none)
//   o_fwd_ic/o_fwd_dc   : forward the returning data to that owner
//   o_outstanding_ic/dc : live load count per owner
//   o_tag_error         : sticky, a return hit an unused entry
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_alloc_en,
  input  logic [TAG_W-1:0] i_alloc_tag,
  input  logic             i_alloc_owner,
  input  logic             i_squash,
  input  logic [TAG_W-1:0] i_ret_tag,
  output logic             o_fwd_ic,
  output logic             o_fwd_dc,
  output logic [3:0]       o_outstanding_ic,
  output logic [3:0]       o_outstanding_dc,
  output logic             o_tag_error
);

  ARB_TAG_ENTRY r_table [NUM_TAGS];
  ARB_TAG_ENTRY w_next  [NUM_TAGS];
  ARB_TAG_ENTRY w_ret_entry;
  logic         w_ret_valid;
  logic         w_ret_live;
  logic         w_ret_bad;
  logic         r_tag_error;

  // Return lookup uses the registered table; a squash arriving with the
  // return kills an icache delivery immediately.
  always_comb begin
    w_ret_entry = r_table[i_ret_tag];
    w_ret_valid = (i_ret_tag != '0) && w_ret_entry.valid;
    w_ret_bad   = (i_ret_tag != '0) && !w_ret_entry.valid;
    w_ret_live  = w_ret_valid && !w_ret_entry.squashed &&
                  !(i_squash && (w_ret_entry.owner == ARB_IC));
    o_fwd_ic    = w_ret_live && (w_ret_entry.owner == ARB_IC);
    o_fwd_dc    = w_ret_live && (w_ret_entry.owner == ARB_DC);
  end

  // Order matters: clear on return, then squash, then allocation wins.
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      w_next[i] = r_table[i];
      if (w_ret_valid && (i_ret_tag == TAG_W'(i)))
        w_next[i] = '0;
      if (i_squash && w_next[i].valid && (w_next[i].owner == ARB_IC))
        w_next[i].squashed = 1'b1;
      if (i_alloc_en && (i != 0) && (i_alloc_tag == TAG_W'(i))) begin
        w_next[i].valid    = 1'b1;
        w_next[i].owner    = ARB_OWNER'(i_alloc_owner);
        w_next[i].squashed = i_squash && (i_alloc_owner == ARB_IC);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) r_table[i] <= '0;
      r_tag_error <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) r_table[i] <= w_next[i];
      if (w_ret_bad) r_tag_error <= 1'b1;
    end
  end

  // Entry 0 is never allocated, so at most 15 live entries: 4 bits suffice.
  always_comb begin
    o_outstanding_ic = '0;
    o_outstanding_dc = '0;
    for (int i = 1; i < NUM_TAGS; i++) begin
      if (r_table[i].valid && !r_table[i].squashed) begin
        if (r_table[i].owner == ARB_IC) o_outstanding_ic = o_outstanding_ic + 4'd1;
        else                            o_outstanding_dc = o_outstanding_dc + 4'd1;
      end
    end
  end

  assign o_tag_error = r_tag_error;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (icache/dcache) arbiter onto the single unified memory port.
// Grants one request per cycle (dcache priority, with an icache starvation
// override), routes memory's accept tag to the granted port and returning
// load data to the port that owns the tag; supports icache fetch squash.
// Ports:
//   clock, reset                       : clock, synchronous active-high reset
//   ic_command/addr/squash             : icache request and squash
//   ic_response/ic_data/ic_tag         : icache accept tag and returned data
//   dc_command/addr/data/size          : dcache request
//   dc_response/dc_data_out/dc_tag     : dcache accept tag and returned data
//   proc2mem_*                         : request to memory
//   mem2proc_*                         : accept tag and return from memory
//   outstanding_ic/dc, tag_error       : live load counts, sticky bad-tag flag
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       ic_command,
  input  logic [XLEN-1:0]  ic_addr,
  input  logic             ic_squash,
  output logic [TAG_W-1:0] ic_response,
  output logic [63:0]      ic_data,
  output logic [TAG_W-1:0] ic_tag,
  input  logic [1:0]       dc_command,
  input  logic [XLEN-1:0]  dc_addr,
  input  logic [63:0]      dc_data,
  input  logic [1:0]       dc_size,
  output logic [TAG_W-1:0] dc_response,
  output logic [63:0]      dc_data_out,
  output logic [TAG_W-1:0] dc_tag,
  output logic [1:0]       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [1:0]       proc2mem_size,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic [3:0]       outstanding_ic,
  output logic [3:0]       outstanding_dc,
  output logic             tag_error
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  function automatic logic [SW-1:0] starve_sat_inc(input logic [SW-1:0] cnt);
    return (cnt == LIMIT) ? LIMIT : cnt + SW'(1);
  endfunction

  logic [SW-1:0]    r_starve_cnt;
  logic             w_ic_req, w_dc_req;
  logic             w_ic_grant, w_dc_grant;
  logic             w_alloc_en;
  logic [TAG_W-1:0] w_ret_tag;
  logic             w_fwd_ic, w_fwd_dc;

  assign w_ic_req   = (ic_command != BUS_NONE);
  assign w_dc_req   = (dc_command != BUS_NONE);
  assign w_ic_grant = !reset && w_ic_req && (!w_dc_req || (r_starve_cnt == LIMIT));
  assign w_dc_grant = !reset && w_dc_req && !w_ic_grant;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    if (w_ic_grant) begin
      proc2mem_command = ic_command;
      proc2mem_addr    = ic_addr;
      proc2mem_size    = DOUBLE;
    end else if (w_dc_grant) begin
      proc2mem_command = dc_command;
      proc2mem_addr    = dc_addr;
      proc2mem_data    = dc_data;
      proc2mem_size    = dc_size;
    end
  end

  assign ic_response = w_ic_grant ? mem2proc_response : '0;
  assign dc_response = w_dc_grant ? mem2proc_response : '0;

  // proc2mem_command is BUS_NONE without a grant, so no separate grant term.
  assign w_alloc_en = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
  assign w_ret_tag  = reset ? '0 : mem2proc_tag;

  always_ff @(posedge clock) begin
    if (reset)                       r_starve_cnt <= '0;
    else if (w_ic_req && !w_ic_grant) r_starve_cnt <= starve_sat_inc(r_starve_cnt);
    else                             r_starve_cnt <= '0;
  end

  mem_tag_table u_tag_table (
    .clock            (clock),
    .reset            (reset),
    .i_alloc_en       (w_alloc_en),
    .i_alloc_tag      (mem2proc_response),
    .i_alloc_owner    (w_dc_grant),
    .i_squash         (ic_squash),
    .i_ret_tag        (w_ret_tag),
    .o_fwd_ic         (w_fwd_ic),
    .o_fwd_dc         (w_fwd_dc),
    .o_outstanding_ic (outstanding_ic),
    .o_outstanding_dc (outstanding_dc),
    .o_tag_error      (tag_error)
  );

  assign ic_tag      = w_fwd_ic ? mem2proc_tag  : '0;
  assign ic_data     = w_fwd_ic ? mem2proc_data : '0;
  assign dc_tag      = w_fwd_dc ? mem2proc_tag  : '0;
  assign dc_data_out = w_fwd_dc ? mem2proc_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter. The driver acts as both
// caches and as memory; a behavioural model predicts accept tags, returned
// data and per-cycle bus/counter state into queues that a separate
// negedge monitor pops and compares.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        clock, reset;
  logic [1:0]  ic_command;  logic [31:0] ic_addr;  logic ic_squash;
  logic [3:0]  ic_response; logic [63:0] ic_data;  logic [3:0] ic_tag;
  logic [1:0]  dc_command;  logic [31:0] dc_addr;  logic [63:0] dc_data; logic [1:0] dc_size;
  logic [3:0]  dc_response; logic [63:0] dc_data_out; logic [3:0] dc_tag;
  logic [1:0]  proc2mem_command; logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;    logic [1:0]  proc2mem_size;
  logic [3:0]  mem2proc_response; logic [63:0] mem2proc_data; logic [3:0] mem2proc_tag;
  logic [3:0]  outstanding_ic, outstanding_dc;
  logic        tag_error;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .ic_command(ic_command), .ic_addr(ic_addr), .ic_squash(ic_squash),
    .ic_response(ic_response), .ic_data(ic_data), .ic_tag(ic_tag),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data), .dc_size(dc_size),
    .dc_response(dc_response), .dc_data_out(dc_data_out), .dc_tag(dc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .outstanding_ic(outstanding_ic), .outstanding_dc(outstanding_dc),
    .tag_error(tag_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [3:0]  tag;
    logic [63:0] data;
  } ev_t;

  typedef struct {
    int          cyc;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic [3:0]  oic, odc;
    logic        terr;
  } st_t;

  ev_t q_icr[$], q_dcr[$], q_ict[$], q_dct[$];
  st_t q_st[$];

  int checks = 0, failures = 0;
  int cur_cyc = 0;
  bit mon_on = 0;

  // Model: owner per tag (-1 free, 0 icache, 1 dcache) plus squash marks.
  int m_owner [16];
  bit m_sq    [16];
  int m_starve;
  bit m_terr;
  bit g_ic_acc, g_dc_acc;

  function automatic int live_count(input int who);
    int n = 0;
    for (int t = 1; t < 16; t++) if (m_owner[t] == who && !m_sq[t]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < 16; t++) begin m_owner[t] = -1; m_sq[t] = 0; end
    m_starve = 0;
    m_terr   = 0;
  endtask

  task automatic step(input logic rst, input logic [1:0] icc, input logic [31:0] ica,
                      input logic sq, input logic [1:0] dcc, input logic [31:0] dca,
                      input logic [63:0] dcd, input logic [1:0] dcs, input logic [3:0] resp,
                      input logic [3:0] rtag, input logic [63:0] rdata);
    st_t s;
    bit icg, dcg;
    reset = rst; ic_command = icc; ic_addr = ica; ic_squash = sq;
    dc_command = dcc; dc_addr = dca; dc_data = dcd; dc_size = dcs;
    mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdata;
    cur_cyc++;
    s.cyc = cur_cyc; s.cmd = 2'd0; s.addr = '0; s.data = '0; s.size = 2'd0;
    s.oic = 4'(live_count(0)); s.odc = 4'(live_count(1)); s.terr = m_terr;
    g_ic_acc = 0; g_dc_acc = 0;
    if (rst) begin
      q_st.push_back(s);
      model_clear();
    end else begin
      icg = (icc != 2'd0) && ((dcc == 2'd0) || m_starve == LIMIT);
      dcg = (dcc != 2'd0) && !icg;
      if (icg) begin s.cmd = icc; s.addr = ica; s.size = 2'd3; end
      else if (dcg) begin s.cmd = dcc; s.addr = dca; s.data = dcd; s.size = dcs; end
      q_st.push_back(s);
      if (icg && resp != 0) q_icr.push_back('{cur_cyc, resp, 64'd0});
      if (dcg && resp != 0) q_dcr.push_back('{cur_cyc, resp, 64'd0});
      g_ic_acc = icg && resp != 0;
      g_dc_acc = dcg && resp != 0;
      if (rtag != 0) begin
        if (m_owner[rtag] >= 0) begin
          if (!m_sq[rtag] && !(sq && m_owner[rtag] == 0)) begin
            if (m_owner[rtag] == 0) q_ict.push_back('{cur_cyc, rtag, rdata});
            else                    q_dct.push_back('{cur_cyc, rtag, rdata});
          end
          m_owner[rtag] = -1; m_sq[rtag] = 0;
        end else m_terr = 1;
      end
      if (sq) for (int t = 1; t < 16; t++) if (m_owner[t] == 0) m_sq[t] = 1;
      if ((g_ic_acc && icc == 2'd1) || (g_dc_acc && dcc == 2'd1)) begin
        m_owner[resp] = g_dc_acc ? 1 : 0;
        m_sq[resp]    = sq && g_ic_acc;
      end
      if (icc != 2'd0 && !icg) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                     m_starve = 0;
    end
    mon_on = 1;
    @(posedge clock); #1;
  endtask

  task automatic cyc(input logic [1:0] icc, input logic [31:0] ica, input logic sq,
                     input logic [1:0] dcc, input logic [31:0] dca, input logic [3:0] resp,
                     input logic [3:0] rtag, input logic [63:0] rdata);
    step(1'b0, icc, ica, sq, dcc, dca, 64'h1111_2222_3333_4444, 2'd2, resp, rtag, rdata);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(2'd0, 32'd0, 1'b0, 2'd0, 32'd0, 4'd0, 4'd0, 64'd0);
  endtask

  // ---------------- monitor ----------------
  task automatic cmp_ev(input string name, input bit exp_p, input logic [3:0] et,
                        input logic [63:0] ed, input logic [3:0] at, input logic [63:0] ad,
                        input bit chk_data);
    checks++;
    if ((exp_p != (at != 0)) || (exp_p && at != et) || (exp_p && chk_data && ad != ed)) begin
      failures++;
      $display("FAIL %s cyc=%0d actual tag=%0h data=%h required present=%0d tag=%0h data=%h",
               name, cur_cyc, at, ad, exp_p, et, ed);
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cur_cyc, act, exp_v);
    end
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      ev_t e;
      st_t s;
      bit  p;
      e = '{0, 4'd0, 64'd0};
      p = q_icr.size() > 0 && q_icr[0].cyc == cur_cyc; e = p ? q_icr.pop_front() : '{0, 4'd0, 64'd0};
      cmp_ev("ic_response", p, e.tag, e.data, ic_response, 64'd0, 1'b0);
      p = q_dcr.size() > 0 && q_dcr[0].cyc == cur_cyc; e = p ? q_dcr.pop_front() : '{0, 4'd0, 64'd0};
      cmp_ev("dc_response", p, e.tag, e.data, dc_response, 64'd0, 1'b0);
      p = q_ict.size() > 0 && q_ict[0].cyc == cur_cyc; e = p ? q_ict.pop_front() : '{0, 4'd0, 64'd0};
      cmp_ev("ic_return", p, e.tag, e.data, ic_tag, ic_data, 1'b1);
      p = q_dct.size() > 0 && q_dct[0].cyc == cur_cyc; e = p ? q_dct.pop_front() : '{0, 4'd0, 64'd0};
      cmp_ev("dc_return", p, e.tag, e.data, dc_tag, dc_data_out, 1'b1);
      if (q_st.size() > 0 && q_st[0].cyc == cur_cyc) begin
        s = q_st.pop_front();
        cmp("proc2mem_command", 64'(proc2mem_command), 64'(s.cmd));
        cmp("proc2mem_addr",    64'(proc2mem_addr),    64'(s.addr));
        cmp("proc2mem_data",    proc2mem_data,         s.data);
        cmp("proc2mem_size",    64'(proc2mem_size),    64'(s.size));
        cmp("outstanding_ic",   64'(outstanding_ic),   64'(s.oic));
        cmp("outstanding_dc",   64'(outstanding_dc),   64'(s.odc));
        cmp("tag_error",        64'(tag_error),        64'(s.terr));
      end else begin
        checks++; failures++;
        $display("FAIL status_record cyc=%0d actual=none required=one", cur_cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0]  h_icc, h_dcc, h_dcs;
  logic [31:0] h_ica, h_dca;
  logic [63:0] h_dcd;
  bit          ic_hold, dc_hold;

  task automatic random_cycle(input bit bad_ret);
    logic [3:0] rtag, resp;
    int         vl[$], fl[$];
    logic       sq;
    if (!ic_hold) begin
      h_icc = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd0;
      h_ica = $urandom & 32'hFFFF_FFF8;
    end
    if (!dc_hold) begin
      h_dcc = 2'($urandom_range(0, 2));
      h_dca = $urandom;
      h_dcd = {$urandom, $urandom};
      h_dcs = 2'($urandom_range(0, 3));
    end
    rtag = 4'd0;
    for (int t = 1; t < 16; t++) if (m_owner[t] >= 0) vl.push_back(t); else fl.push_back(t);
    if (bad_ret && fl.size() > 0) rtag = 4'(fl[$urandom_range(0, fl.size() - 1)]);
    else if (vl.size() > 0 && $urandom_range(0, 99) < 35) rtag = 4'(vl[$urandom_range(0, vl.size() - 1)]);
    if (rtag != 0 && m_owner[rtag] >= 0) fl.push_back(int'(rtag));
    resp = 4'd0;
    if ((h_icc != 0 || h_dcc != 0) && $urandom_range(0, 3) != 0 && fl.size() > 0)
      resp = 4'(fl[$urandom_range(0, fl.size() - 1)]);
    sq = ($urandom_range(0, 9) == 0);
    step(1'b0, h_icc, h_ica, sq, h_dcc, h_dca, h_dcd, h_dcs, resp, rtag, {$urandom, $urandom});
    ic_hold = (h_icc != 0) && !g_ic_acc;
    dc_hold = (h_dcc != 0) && !g_dc_acc;
  endtask

  initial begin
    reset = 1'b1; ic_command = 0; ic_addr = 0; ic_squash = 0;
    dc_command = 0; dc_addr = 0; dc_data = 0; dc_size = 0;
    mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
    model_clear();
    ic_hold = 0; dc_hold = 0;
    @(posedge clock); #1;
    // Reset with requests and a memory accept present: all gated off.
    for (int k = 0; k < 3; k++)
      step(1'b1, 2'd1, 32'h100, 1'b0, 2'd1, 32'h200, 64'd5, 2'd3, 4'd9, 4'd0, 64'd0);
    // Icache-only load, tag 3, then data return.
    cyc(2'd1, 32'h1000, 0, 2'd0, 0, 4'd3, 4'd0, 64'd0);
    idle(1);
    cyc(2'd0, 0, 0, 2'd0, 0, 4'd0, 4'd3, 64'hDEADBEEF_00000013);
    idle(1);
    // Both load: dcache wins, icache retries next cycle.
    cyc(2'd1, 32'h2000, 0, 2'd1, 32'h3000, 4'd1, 4'd0, 64'd0);
    cyc(2'd1, 32'h2000, 0, 2'd0, 0, 4'd2, 4'd0, 64'd0);
    cyc(2'd0, 0, 0, 2'd0, 0, 4'd0, 4'd1, 64'hA1);
    cyc(2'd0, 0, 0, 2'd0, 0, 4'd0, 4'd2, 64'hA2);
    // Starvation: four denials, then icache gets one grant.
    for (int k = 0; k < 6; k++)
      cyc((k < 5) ? 2'd1 : 2'd0, 32'h4000, 0, 2'd1, 32'h5000 + 32'(k * 8), 4'(k + 1), 4'd0, 64'd0);
    for (int k = 1; k <= 6; k++) cyc(2'd0, 0, 0, 2'd0, 0, 4'd0, 4'(k), 64'(k * 16));
    // Squash two fetches, then both return.
    cyc(2'd1, 32'h6000, 0, 2'd0, 0, 4'd1, 4'd0, 64'd0);
    cyc(2'd1, 32'h6008, 0, 2'd0, 0, 4'd2, 4'd0, 64'd0);
    cyc(2'd0, 0, 1, 2'd0, 0, 4'd0, 4'd0, 64'd0);
    cyc(2'd0, 0, 0, 2'd0, 0, 4'd0, 4'd1, 64'hB1);
    cyc(2'd0, 0, 0, 2'd0, 0, 4'd0, 4'd2, 64'hB2);
    // Return of tag 7 to dcache while tag 7 is reallocated to icache.
    cyc(2'd0, 0, 0, 2'd1, 32'h7000, 4'd7, 4'd0, 64'd0);
    cyc(2'd1, 32'h7008, 0, 2'd0, 0, 4'd7, 4'd7, 64'hC7);
    idle(1);
    cyc(2'd0, 0, 0, 2'd0, 0, 4'd0, 4'd7, 64'hD7);
    // Squash coinciding with an icache return: dropped, entry cleared.
    cyc(2'd1, 32'h8000, 0, 2'd0, 0, 4'd8, 4'd0, 64'd0);
    cyc(2'd0, 0, 1, 2'd0, 0, 4'd0, 4'd8, 64'hE8);
    // Store allocates nothing; unsolicited return of its tag is an error.
    cyc(2'd0, 0, 0, 2'd2, 32'h9000, 4'd5, 4'd0, 64'd0);
    cyc(2'd0, 0, 0, 2'd0, 0, 4'd0, 4'd5, 64'hF5);
    idle(2);
    for (int k = 0; k < 2; k++)
      step(1'b1, 2'd0, 0, 1'b0, 2'd0, 0, 64'd0, 2'd0, 4'd0, 4'd0, 64'd0);
    idle(1);
    // Random traffic with one mid-run reset (memory idle across it).
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500 || i == 1501) begin
        step(1'b1, h_icc, h_ica, 1'b0, h_dcc, h_dca, h_dcd, h_dcs, 4'd0, 4'd0, 64'd0);
        ic_hold = 0; dc_hold = 0;
      end else begin
        random_cycle(i == 1400 || i == 2900);
      end
    end
    idle(1);
    checks++;
    if (q_icr.size() + q_dcr.size() + q_ict.size() + q_dct.size() + q_st.size() != 0) begin
      failures++;
      $display("FAIL queues_drained actual=%0d required=0",
               q_icr.size() + q_dcr.size() + q_ict.size() + q_dct.size() + q_st.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter between the instruction cache and data cache controllers and the single unified-memory port (`mem`) driven from the processor top. It grants one bus request per cycle and passes memory's response tag back to the granted requester. It records which port owns each outstanding load tag and routes returning data to that owner. It also supports squashing in-flight instruction fetches on a branch mispredict.

## Interface
- `STARVE_LIMIT`, 4: consecutive denied icache cycles after which icache gets priority for one grant.
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `ic_command`  in  2  icache request (BUS_NONE/BUS_LOAD; BUS_STORE is illegal)
- `ic_addr`  in  `XLEN`  icache address, 8-byte aligned
- `ic_squash`  in  1  drop every icache load outstanding at this edge
- `ic_response`  out  4  tag accepted for the icache request this cycle; 0 means retry
- `ic_data`  out  64  returned data
- `ic_tag`  out  4  nonzero means `ic_data` is valid for this tag
- `dc_command`  in  2  dcache request (BUS_NONE/BUS_LOAD/BUS_STORE)
- `dc_addr`  in  `XLEN`  dcache address
- `dc_data`  in  64  store data
- `dc_size`  in  MEM_SIZE  access size
- `dc_response`, `dc_data_out`, `dc_tag`  out  4/64/4  same meaning as the icache outputs
- `proc2mem_command`, `proc2mem_addr`, `proc2mem_data`, `proc2mem_size`  out  to `mem`
- `mem2proc_response`, `mem2proc_data`, `mem2proc_tag`  in  from `mem`
- `outstanding_ic`, `outstanding_dc`  out  4  live load-tag count per port
- `tag_error`  out  1  sticky: memory returned a tag that is not in the table

## Operation
- **Grant selection (combinational):**
  - Default priority is dcache.
  - When `starve_cnt == STARVE_LIMIT` and icache is requesting, icache wins.
  - Only the granted port's command, address, data and size drive `proc2mem_*`.
  - Icache size is always DOUBLE and its data is 0.
  - With no grant, `proc2mem_command` is BUS_NONE.
- **Response:**
  - `mem2proc_response` goes to the granted port's `*_response`.
  - The losing port sees 0 and must hold its request and retry.
- **Tag table:**
  - 16 entries, each holding {valid, owner, squashed}. Entry 0 is never used.
  - An accepted BUS_LOAD (response ≠ 0) sets valid=1, owner=port, squashed=0 at the edge.
  - Accepted stores allocate nothing.
- **Return routing:**
  - When `mem2proc_tag` ≠ 0 and the entry is valid, the arbiter forwards tag and data to the owner and clears the entry at the edge.
  - A squashed entry is cleared without being forwarded.
  - The non-owner port always sees tag 0.
  - A return with an invalid entry sets `tag_error` and forwards nothing.
- **Squash:**
  - `ic_squash` marks every valid icache entry squashed and decrements `outstanding_ic` accordingly.
  - A load accepted in the same cycle as `ic_squash` is also squashed.
- **Starvation counter:**
  - Increments (saturating at `STARVE_LIMIT`) when icache requests and is not granted.
  - Resets to 0 on an icache grant, or when icache is idle.
- **Counters:** count valid, non-squashed entries per owner; 4-bit, never wrap, maximum 15.

## Timing
- Request, response and data-return paths are combinational (zero latency). Table, counters and `tag_error` update at posedge.
- Return lookup reads the registered table.
- Same tag returned and re-allocated in one cycle: clear happens first, allocation wins, and the entry ends valid for the new owner.
- Simultaneous return and squash of an icache tag: the data is not forwarded and the entry is cleared.
- Reset (including mid-transaction):
  - Table, `starve_cnt`, outstanding counters and `tag_error` go to 0.
  - While reset is high, `proc2mem_command` is BUS_NONE, both responses are 0 and both return tags are 0.
  - Data returning after reset for pre-reset tags sets `tag_error`; the bench must idle memory across reset.

## Structure
- The BUS_* command encoding, MEM_SIZE and the 4-bit tag width come from the shared package already used by `mem`.
- Add to that package: `ARB_OWNER` enum {ARB_IC, ARB_DC} and `ARB_TAG_ENTRY` struct {valid, owner, squashed}.
- Sub-module `mem_tag_table`: holds the 16-entry table, the allocate/clear/squash logic and the per-owner counts. The top level holds grant selection, the starvation counter and muxing.

## Test plan
- Icache load only, memory responds tag 3, returns tag 3 with data 0xDEADBEEF_00000013 → `ic_response`=3, `ic_tag`=3 with that data, `dc_tag`=0, `outstanding_ic` goes 1→0.
- Both ports load the same cycle → dcache granted; `ic_response`=0; icache granted the next cycle once dcache goes idle.
- Dcache loads continuously for 6 cycles while icache requests → icache granted in the cycle after 4 denials, then dcache resumes.
- Icache loads tags 1 and 2, then `ic_squash`, then memory returns 1 and 2 → `ic_tag` stays 0, `outstanding_ic`=0, `tag_error`=0.
- Dcache store accepted with tag 5 → no table entry; a later unsolicited return of tag 5 sets `tag_error`=1, sticky until reset.
- Return of tag 7 for dcache and a new icache allocation of tag 7 in the same cycle → `dc_tag`=7 this cycle; entry 7 becomes owner=IC, `outstanding_dc` decrements and `outstanding_ic` increments.
